instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RISC-V instruction encoder and instruction-memory loader; it performs the inverse of the control decoder. It accepts symbolic operations (op, rd, rs1, rs2, imm) over a valid/ready handshake and packs them into 32-bit RV32I words covering the same instruction subset the core decodes: add, sub, and, or, lb, lw, sb, sw, beq, blt, bge, addi, jalr and jal. It writes those words sequentially into instruction memory. It sits beside the core as the program loader used by benches and boot logic.

## Interface
- DEPTH, 256: instruction-memory capacity in words.
- ADDR_W, 8: word-address width; must satisfy 2^ADDR_W >= DEPTH.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at word 0.
- in_valid  in  1  operation present.
- in_ready  out  1  encoder can accept an operation this cycle.
- in_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 lb, 5 lw, 6 sb, 7 sw, 8 beq, 9 blt, 10 bge, 11 addi, 12 jalr, 13 jal, 14–15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  21  signed immediate; byte offset for branches and jal.
- in_last  in  1  marks the final operation of the session.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle pulse when the session ends.
- full  out  1  sticky; DEPTH words have been written.
- err  out  1  sticky; at least one operation was rejected.
- err_count  out  8  count of rejected operations; saturates at 255.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start. Entering RUN clears wr_ptr, full, err and err_count.
  - RUN -> FLUSH when an operation with in_last=1 is accepted, or when the accepted write makes the word count reach DEPTH.
  - FLUSH -> DONE after the pending write issues.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- start is ignored outside IDLE.
- in_ready=1 only in RUN with full=0. An operation is accepted when in_valid & in_ready.
- Encoding fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
  - R-type, opcode 0110011: add f3=000/f7=0, sub f3=000/f7=0100000, and f3=111, or f3=110.
  - Loads, opcode 0000011: lb f3=000, lw f3=010. I-type immediate: imm[11:0] goes to [31:20].
  - Stores, opcode 0100011: sb f3=000, sw f3=010. imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7].
  - addi: opcode 0010011, f3=000, I-type immediate.
  - jalr: opcode 1100111, f3=000, I-type immediate.
  - Branches, opcode 1100011: beq f3=000, blt f3=100, bge f3=101. Bit mapping: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - jal: opcode 1101111. Bit mapping: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Fields the format does not use are driven 0.
- Rejection rules: an accepted operation is rejected when any of the following holds.
  - Illegal op (14 or 15).
  - I or S type with in_imm[20:11] not all equal (value outside -2048..2047).
  - Branch with in_imm[20:12] not all equal, or in_imm[0]=1.
  - jal with in_imm[0]=1.
- A rejected operation produces no write and no pointer advance. It sets err and increments err_count. A rejected op carrying in_last still ends the session.

## Timing
- Encoding is registered. The operation accepted in cycle N produces imem_we=1 in cycle N+1, with imem_addr equal to wr_ptr at acceptance. wr_ptr increments at acceptance.
- Throughput is one operation per cycle in RUN. There is no backpressure from memory.
- For an in_last operation accepted in cycle N: its write occurs in N+1 (FLUSH) and done=1 in N+2 (DONE).
- Full boundary: the write of word DEPTH-1 sets full in the same cycle as imem_we. in_ready has already been 0 since acceptance, so no further operation is accepted. Last word plus in_last on the same op takes one FLUSH and then DONE, with no extra cycles.
- Reset values: state IDLE; all outputs 0, including imem_addr and imem_wdata; wr_ptr 0.
- Reset mid-session abandons any pending write. imem_we is 0 on the cycle after reset asserts.

## Test plan
- add rd=3,rs1=1,rs2=2, then addi rd=1,rs1=0,imm=-1 (in_last): required writes 0x002081B3 @0 and 0xFFF00093 @1; done asserted 2 cycles after the last accept.
- sw rs2=5,rs1=2,imm=8; beq rs1=1,rs2=2,imm=-4; jal rd=1,imm=16: required writes 0x00512423, 0xFE208EE3 and 0x010000EF at consecutive addresses.
- addi imm=2048, beq imm=3, op=15: required result is no writes, err=1 and err_count=3. A following valid op must still be written at address 0.
- With DEPTH=4, stream 5 back-to-back ops: required result is 4 writes at addresses 0–3, full=1, in_ready=0 from the 4th accept onward, then done; the 5th op is never accepted.
- Assert reset on the cycle after an accept: required result is no imem_we, state IDLE, all flags cleared. A new start must begin at address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs symbolic RV32I operations into instruction words and loads them into imem from word 0.
// Write lands one cycle after accept, one op/cycle; in_ready is low outside RUN and once full.
module instr_encoder #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [20:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              done,
   output logic              full,
   output logic              err,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   typedef struct packed {
      logic        bad;
      logic [31:0] word;
   } enc_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   state_t          state;
   state_t          state_nxt;
   logic [ADDR_W:0] wr_ptr;
   logic            accept;
   logic            imm_i_ok;
   logic            imm_b_ok;
   logic            last_word;
   enc_t            enc;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (accept && (in_last || last_word)) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == RUN) && !full;
      done     = (state == DONE);
      accept   = in_valid && in_ready;
   end

   // Sign-extension check: the dropped upper bits must all match the kept sign bit.
   assign imm_i_ok  = (&in_imm[20:11]) | ~(|in_imm[20:11]);
   assign imm_b_ok  = ((&in_imm[20:12]) | ~(|in_imm[20:12])) & ~in_imm[0];
   assign last_word = !enc.bad && (wr_ptr == LAST_PTR);

   always_comb begin
      enc = '0;
      case (in_op)
         4'd0:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
         4'd1:  enc.word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
         4'd2:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
         4'd3:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
         4'd4:  enc = '{!imm_i_ok, {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_LOAD}};
         4'd5:  enc = '{!imm_i_ok, {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD}};
         4'd6:  enc = '{!imm_i_ok, {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], OPC_STORE}};
         4'd7:  enc = '{!imm_i_ok, {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE}};
         4'd8:  enc = '{!imm_b_ok, {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                                    in_imm[4:1], in_imm[11], OPC_BRANCH}};
         4'd9:  enc = '{!imm_b_ok, {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b100,
                                    in_imm[4:1], in_imm[11], OPC_BRANCH}};
         4'd10: enc = '{!imm_b_ok, {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b101,
                                    in_imm[4:1], in_imm[11], OPC_BRANCH}};
         4'd11: enc = '{!imm_i_ok, {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_IMM}};
         4'd12: enc = '{!imm_i_ok, {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR}};
         4'd13: enc = '{in_imm[0], {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                    in_rd, OPC_JAL}};
         default: enc.bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
      end else begin
         imem_we <= accept && !enc.bad;
         if (state == IDLE && start) begin
            wr_ptr    <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
         end
         if (accept) begin
            if (enc.bad) begin
               err <= 1'b1;
               if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
               imem_addr  <= wr_ptr[ADDR_W-1:0];
               imem_wdata <= enc.word;
               wr_ptr     <= wr_ptr + 1'b1;
               // full rises together with the write strobe of the last word
               if (last_word) full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, rejection, full boundary, mid-session reset,
// plus random sessions against an arithmetic encoding model (DEPTH=256 and DEPTH=4 instances).
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [20:0] in_imm = '0;

   logic        in_ready, imem_we, done, full, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [7:0]  err_count;

   logic        in_ready_4, imem_we_4, done_4, full_4, err_4;
   logic [1:0]  imem_addr_4;
   logic [31:0] imem_wdata_4;
   logic [7:0]  err_count_4;

   int errors = 0;
   int checks = 0;
   bit sel4 = 1'b0;

   int unsigned wa[$];
   logic [31:0] wd[$];
   int unsigned wa4[$];
   logic [31:0] wd4[$];

   instr_encoder dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .done(done), .full(full), .err(err), .err_count(err_count)
   );

   instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut4 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_4),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .imem_we(imem_we_4), .imem_addr(imem_addr_4),
      .imem_wdata(imem_wdata_4), .done(done_4), .full(full_4), .err(err_4),
      .err_count(err_count_4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wa.push_back(int'(imem_addr));
         wd.push_back(imem_wdata);
      end
      if (imem_we_4 === 1'b1) begin
         wa4.push_back(int'(imem_addr_4));
         wd4.push_back(imem_wdata_4);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   // Reference model: field placement computed with plain arithmetic on the immediate value.
   function automatic logic [31:0] model_word(input logic [3:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [20:0] imm);
      int unsigned u, r, opc, f3, base;
      u    = int'($signed(imm));
      r    = 0;
      base = rs1 * 32768 + rs2 * (1 << 20);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            f3 = (op == 4'd2) ? 7 : (op == 4'd3) ? 6 : 0;
            r  = 51 + rd * 128 + f3 * 4096 + base + ((op == 4'd1) ? 32 * (1 << 25) : 0);
         end
         4'd4, 4'd5, 4'd11, 4'd12: begin
            opc = (op == 4'd11) ? 19 : (op == 4'd12) ? 103 : 3;
            f3  = (op == 4'd5) ? 2 : 0;
            r   = opc + rd * 128 + f3 * 4096 + rs1 * 32768 + (u % 4096) * (1 << 20);
         end
         4'd6, 4'd7: begin
            f3 = (op == 4'd7) ? 2 : 0;
            r  = 35 + (u % 32) * 128 + f3 * 4096 + base + ((u / 32) % 128) * (1 << 25);
         end
         4'd8, 4'd9, 4'd10: begin
            f3 = (op == 4'd8) ? 0 : (op == 4'd9) ? 4 : 5;
            r  = 99 + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 + f3 * 4096 + base
                 + ((u / 32) % 64) * (1 << 25) + ((u / 4096) % 2) * 32'h8000_0000;
         end
         4'd13: begin
            r = 111 + rd * 128 + ((u / 4096) % 256) * 4096 + ((u / 2048) % 2) * (1 << 20)
                + ((u / 2) % 1024) * (1 << 21) + ((u / (1 << 20)) % 2) * 32'h8000_0000;
         end
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic bit model_reject(input logic [3:0] op, input logic [20:0] imm);
      int s;
      s = int'($signed(imm));
      if (op > 4'd13) return 1'b1;
      if (op inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12}) return (s < -2048 || s > 2047);
      if (op inside {4'd8, 4'd9, 4'd10}) return (s < -4096 || s > 4095 || (s % 2) != 0);
      if (op == 4'd13) return (s % 2) != 0;
      return 1'b0;
   endfunction

   task automatic idle_inputs();
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
   endtask

   task automatic begin_session();
      wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one op and return at the negedge just after it was accepted.
   task automatic send_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [20:0] imm, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_last = last;
      while (((sel4 ? in_ready_4 : in_ready) !== 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) begin
         checks++; errors++;
         $display("FAIL send_op: in_ready stayed %b for 20 cycles, required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, imem_we, done, full, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: ready/we/done/full/err=%b required 00000",
                  {in_ready, imem_we, done, full, err});
      end
      checks++;
      if (imem_addr !== 8'd0 || imem_wdata !== 32'd0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h err_count=%0d required 0/0/0",
                  imem_addr, imem_wdata, err_count);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: in_ready=%b without start, required 0", in_ready);
      end
   endtask

   task automatic test_basic();
      begin_session();
      send_op(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
      send_op(4'd11, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 1'b1);
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'hFFF00093) begin
         errors++;
         $display("FAIL basic_last_write: we=%b addr=%0d data=%h required 1/1/fff00093",
                  imem_we, imem_addr, imem_wdata);
      end
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_flush: done=%b in_ready=%b required 0/0", done, in_ready);
      end
      idle_inputs();
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL basic_done: done=%b two cycles after last accept, required 1", done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: done=%b, required 0 after one cycle", done);
      end
      checks++;
      if (wa.size() != 2) begin
         errors++;
         $display("FAIL basic_count: %0d writes, required 2", wa.size());
      end else if (wa[0] != 0 || wd[0] !== 32'h002081B3) begin
         errors++;
         $display("FAIL basic_add: addr=%0d data=%h required 0/002081b3", wa[0], wd[0]);
      end
   endtask

   task automatic test_formats();
      logic [31:0] exp_w[3];
      int c;
      exp_w[0] = 32'h00512423; exp_w[1] = 32'hFE208EE3; exp_w[2] = 32'h010000EF;
      begin_session();
      send_op(4'd7, 5'd7, 5'd2, 5'd5, 21'd8, 1'b0);
      send_op(4'd8, 5'd9, 5'd1, 5'd2, 21'h1FFFFC, 1'b0);
      send_op(4'd13, 5'd1, 5'd3, 5'd4, 21'd16, 1'b1);
      idle_inputs();
      wait_done(c);
      @(negedge clk);
      checks++;
      if (wa.size() != 3) begin
         errors++;
         $display("FAIL formats_count: %0d writes, required 3", wa.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wa[i] != i || wd[i] !== exp_w[i]) begin
               errors++;
               $display("FAIL formats_word%0d: addr=%0d data=%h required %0d/%h",
                        i, wa[i], wd[i], i, exp_w[i]);
            end
         end
      end
   endtask

   task automatic test_reject();
      int c;
      begin_session();
      send_op(4'd11, 5'd1, 5'd2, 5'd0, 21'd2048, 1'b0);
      send_op(4'd8, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0);
      send_op(4'd15, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0);
      send_op(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1);
      idle_inputs();
      wait_done(c);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || err_count !== 8'd3) begin
         errors++;
         $display("FAIL reject_flags: err=%b err_count=%0d required 1/3", err, err_count);
      end
      checks++;
      if (wa.size() != 1) begin
         errors++;
         $display("FAIL reject_count: %0d writes, required 1", wa.size());
      end else if (wa[0] != 0 || wd[0] !== 32'h002081B3) begin
         errors++;
         $display("FAIL reject_next: addr=%0d data=%h required 0/002081b3", wa[0], wd[0]);
      end
   endtask

   task automatic test_full();
      int acc, dones, rdy_late;
      logic full_at_last;
      acc = 0; dones = 0; rdy_late = 0; full_at_last = 1'b0;
      sel4 = 1'b1;
      begin_session();
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1; in_op = 4'd0; in_last = 1'b0; in_imm = '0;
         in_rd = 5'(acc + 1); in_rs1 = 5'(acc); in_rs2 = 5'(acc + 10);
         if (in_ready_4 === 1'b1) acc++;
         @(negedge clk);
         if (acc >= 4 && in_ready_4 !== 1'b0) rdy_late++;
         if (done_4 === 1'b1) dones++;
         if (imem_we_4 === 1'b1 && imem_addr_4 == 2'd3) full_at_last = full_4;
      end
      idle_inputs();
      checks++;
      if (acc != 4 || rdy_late != 0) begin
         errors++;
         $display("FAIL full_accepts: accepts=%0d ready_after_full=%0d required 4/0",
                  acc, rdy_late);
      end
      checks++;
      if (full_at_last !== 1'b1 || full_4 !== 1'b1 || dones != 1) begin
         errors++;
         $display("FAIL full_flag: full_at_write=%b full_now=%b dones=%0d required 1/1/1",
                  full_at_last, full_4, dones);
      end
      checks++;
      if (wa4.size() != 4) begin
         errors++;
         $display("FAIL full_count: %0d writes, required 4", wa4.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa4[i] != i || wd4[i] !== model_word(4'd0, 5'(i + 1), 5'(i), 5'(i + 10), '0))
            begin
               errors++;
               $display("FAIL full_word%0d: addr=%0d data=%h required %0d/%h", i, wa4[i],
                        wd4[i], i, model_word(4'd0, 5'(i + 1), 5'(i), 5'(i + 10), '0));
            end
         end
      end
      sel4 = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int c;
      begin_session();
      send_op(4'd15, 5'd0, 5'd0, 5'd0, 21'd0, 1'b0);
      send_op(4'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_ctrl: we=%b ready=%b done=%b required 0/0/0",
                  imem_we, in_ready, done);
      end
      checks++;
      if (err !== 1'b0 || err_count !== 8'd0 || full !== 1'b0 || imem_addr !== 8'd0) begin
         errors++;
         $display("FAIL midreset_flags: err=%b cnt=%0d full=%b addr=%0d required all 0",
                  err, err_count, full, imem_addr);
      end
      reset = 1'b0;
      @(negedge clk);
      begin_session();
      send_op(4'd11, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 1'b1);
      idle_inputs();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hFFF00093) begin
         errors++;
         $display("FAIL midreset_restart: we=%b addr=%0d data=%h required 1/0/fff00093",
                  imem_we, imem_addr, imem_wdata);
      end
      wait_done(c);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [3:0]  ops[24];
      logic [4:0]  rds[24], r1s[24], r2s[24];
      logic [20:0] imms[24];
      logic [31:0] exp_d[$];
      logic [31:0] exp4[$];
      int          bl[10];
      int          n, v, ecnt, ecnt4, c;
      bit          stop4;
      bl = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, -4097};
      for (int s = 0; s < 10; s++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            ops[i] = 4'($urandom_range(0, 15));
            rds[i] = 5'($urandom); r1s[i] = 5'($urandom); r2s[i] = 5'($urandom);
            case ($urandom_range(0, 3))
               0:       v = int'($urandom_range(0, 4000)) - 2000;
               1:       v = bl[$urandom_range(0, 9)];
               2:       v = int'($urandom_range(0, 2097151)) - 1048576;
               default: v = (int'($urandom_range(0, 1000)) - 500) * 2;
            endcase
            imms[i] = 21'(v);
         end
         exp_d.delete(); exp4.delete(); ecnt = 0; ecnt4 = 0; stop4 = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (model_reject(ops[i], imms[i])) ecnt++;
            else exp_d.push_back(model_word(ops[i], rds[i], r1s[i], r2s[i], imms[i]));
            if (!stop4) begin
               if (model_reject(ops[i], imms[i])) ecnt4++;
               else exp4.push_back(model_word(ops[i], rds[i], r1s[i], r2s[i], imms[i]));
               if (exp4.size() == 4 || i == n - 1) stop4 = 1'b1;
            end
         end
         begin_session();
         for (int i = 0; i < n; i++)
            send_op(ops[i], rds[i], r1s[i], r2s[i], imms[i], i == n - 1);
         idle_inputs();
         wait_done(c);
         checks++;
         if (c != 1) begin
            errors++;
            $display("FAIL rand_done s%0d: done after %0d extra cycles, required 1", s, c);
         end
         repeat (2) @(negedge clk);
         checks++;
         if (err !== (ecnt > 0) || err_count !== 8'(ecnt) || full !== 1'b0) begin
            errors++;
            $display("FAIL rand_flags s%0d: err=%b cnt=%0d full=%b required %0d/%0d/0",
                     s, err, err_count, full, ecnt > 0, ecnt);
         end
         checks++;
         if (err_4 !== (ecnt4 > 0) || err_count_4 !== 8'(ecnt4) ||
             full_4 !== (exp4.size() == 4)) begin
            errors++;
            $display("FAIL rand_flags4 s%0d: err=%b cnt=%0d full=%b required %0d/%0d/%0d",
                     s, err_4, err_count_4, full_4, ecnt4 > 0, ecnt4, exp4.size() == 4);
         end
         checks++;
         if (wa.size() != exp_d.size() || wa4.size() != exp4.size()) begin
            errors++;
            $display("FAIL rand_count s%0d: writes=%0d/%0d required %0d/%0d",
                     s, wa.size(), wa4.size(), exp_d.size(), exp4.size());
         end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
               checks++;
               if (wa[i] != i || wd[i] !== exp_d[i]) begin
                  errors++;
                  $display("FAIL rand_word s%0d.%0d: addr=%0d data=%h required %0d/%h",
                           s, i, wa[i], wd[i], i, exp_d[i]);
               end
            end
            for (int i = 0; i < exp4.size(); i++) begin
               checks++;
               if (wa4[i] != i || wd4[i] !== exp4[i]) begin
                  errors++;
                  $display("FAIL rand_word4 s%0d.%0d: addr=%0d data=%h required %0d/%h",
                           s, i, wa4[i], wd4[i], i, exp4[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_formats();
      test_reject();
      test_full();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
